// File: rtl/layer_sched.sv
// ---------------------------------------------------------------------------
// layer_sched
// Command scheduler for a layer datapath. Commands {op, cnt} are queued in a
// small FIFO and executed one at a time. Weight/bias writes count stream
// beats. Run/pool commands issue one s_init pulse per sample and wait for that
// sample's completion pulse.
//
// Ports
//   AXIS_ACLK, AXIS_ARESETN     clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_cnt             0=WWRITE 1=BWRITE 2=RUN 3=POOL, beat/sample count
//   src_valid, src_ready        stream beat observed when both high
//   s_fin, p_fin                per-sample completion from sample/pool control
//   wwrite, bwrite, run, pool   mode levels (at most one high)
//   s_init                      one-cycle per-sample start pulse
//   last                        final beat/sample of current command in progress
//   busy                        scheduler active or queue non-empty
//   cmd_done                    one-cycle pulse when a command retires
//   remain                      beats/samples left in current command
// ---------------------------------------------------------------------------
module layer_sched #(
    parameter int QDEPTH = 4,
    parameter int CNTW   = 12
) (
    input  logic            AXIS_ACLK,
    input  logic            AXIS_ARESETN,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [CNTW-1:0] cmd_cnt,
    input  logic            src_valid,
    input  logic            src_ready,
    input  logic            s_fin,
    input  logic            p_fin,
    output logic            wwrite,
    output logic            bwrite,
    output logic            run,
    output logic            pool,
    output logic            s_init,
    output logic            last,
    output logic            busy,
    output logic            cmd_done,
    output logic [CNTW-1:0] remain
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        OP_WWRITE = 2'd0,
        OP_BWRITE = 2'd1,
        OP_RUN    = 2'd2,
        OP_POOL   = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RETIRE
    } state_t;

    logic [1:0]      opMem_q  [QDEPTH];
    logic [CNTW-1:0] cntMem_q [QDEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [CW-1:0]   count_q;

    state_t          state_q, state_d;
    op_t             curOp_q, curOp_d;
    logic [CNTW-1:0] remain_q, remain_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic beat;
    logic sampleFin;

    assign full  = (count_q == CW'(QDEPTH));
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign beat  = src_valid && src_ready;

    // Only the completion pulse matching the current op counts; the other is ignored.
    assign sampleFin = (curOp_q == OP_RUN) ? s_fin : p_fin;

    // Ready is forced high while reset is held so upstream never sees a stale full.
    assign cmd_ready = !full || !AXIS_ARESETN;

    // Queue storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge AXIS_ACLK) begin
        if (push) begin
            opMem_q[wrPtr_q]  <= cmd_op;
            cntMem_q[wrPtr_q] <= cmd_cnt;
        end
    end

    // Queue pointers and occupancy; pointer wrap comes free from power-of-2 depth.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            state_q  <= S_IDLE;
            curOp_q  <= OP_WWRITE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            curOp_q  <= curOp_d;
            remain_q <= remain_d;
        end
    end

    // Next-state logic. Remain goes to zero on the final beat/sample so it
    // never wraps, and RETIRE always passes through IDLE before the next pop.
    always_comb begin
        state_d  = state_q;
        curOp_d  = curOp_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    curOp_d  = op_t'(opMem_q[rdPtr_q]);
                    remain_d = (cntMem_q[rdPtr_q] == '0) ? CNTW'(1) : cntMem_q[rdPtr_q];
                    state_d  = opMem_q[rdPtr_q][1] ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    if (remain_q <= CNTW'(1)) begin
                        remain_d = '0;
                        state_d  = S_RETIRE;
                    end else begin
                        remain_d = remain_q - CNTW'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sampleFin) begin
                    if (remain_q > CNTW'(1)) begin
                        remain_d = remain_q - CNTW'(1);
                        state_d  = S_START;
                    end else begin
                        remain_d = '0;
                        state_d  = S_RETIRE;
                    end
                end
            end
            S_RETIRE: begin
                remain_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                remain_d = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so cmd_* cannot reach the modes combinationally.
    always_comb begin
        wwrite   = (state_q == S_LOAD) && (curOp_q == OP_WWRITE);
        bwrite   = (state_q == S_LOAD) && (curOp_q == OP_BWRITE);
        run      = ((state_q == S_START) || (state_q == S_WAIT)) && (curOp_q == OP_RUN);
        pool     = ((state_q == S_START) || (state_q == S_WAIT)) && (curOp_q == OP_POOL);
        s_init   = (state_q == S_START);
        cmd_done = (state_q == S_RETIRE);
        last     = ((state_q == S_LOAD) || (state_q == S_START) || (state_q == S_WAIT))
                   && (remain_q == CNTW'(1));
        busy     = (state_q != S_IDLE) || !empty;
        remain   = remain_q;
    end

endmodule

// File: tb/tb_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_layer_sched
// Directed-plus-random bench for layer_sched. A queue of expected commands
// records what was accepted; each command is then executed from its own
// op/count using the intended behaviour (beat counting, one start pulse per
// sample, retire pulse, idle gap), with randomized beat gaps and spurious
// completion pulses.
// ---------------------------------------------------------------------------
module tb_layer_sched;

    localparam int CNTW = 12;
    localparam logic [1:0] OP_WW   = 2'd0;
    localparam logic [1:0] OP_BW   = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_POOL = 2'd3;

    typedef struct {
        logic [1:0] op;
        int         cnt;
    } cmd_t;

    logic            AXIS_ACLK;
    logic            AXIS_ARESETN;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [CNTW-1:0] cmd_cnt;
    logic            src_valid;
    logic            src_ready;
    logic            s_fin;
    logic            p_fin;
    logic            wwrite;
    logic            bwrite;
    logic            run;
    logic            pool;
    logic            s_init;
    logic            last;
    logic            busy;
    logic            cmd_done;
    logic [CNTW-1:0] remain;

    logic [3:0] modeBus;
    assign modeBus = {wwrite, bwrite, run, pool};

    int   tests;
    int   fails;
    cmd_t expQ[$];

    layer_sched #(.QDEPTH(4), .CNTW(CNTW)) dut (
        .AXIS_ACLK   (AXIS_ACLK),
        .AXIS_ARESETN(AXIS_ARESETN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_cnt     (cmd_cnt),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .s_fin       (s_fin),
        .p_fin       (p_fin),
        .wwrite      (wwrite),
        .bwrite      (bwrite),
        .run         (run),
        .pool        (pool),
        .s_init      (s_init),
        .last        (last),
        .busy        (busy),
        .cmd_done    (cmd_done),
        .remain      (remain)
    );

    initial AXIS_ACLK = 1'b0;
    always #5 AXIS_ACLK = ~AXIS_ACLK;

    task automatic tick();
        @(posedge AXIS_ACLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command and hold it until accepted; record it as expected work.
    task automatic applyStimulus(input logic [1:0] op, input int cnt);
        int   g;
        cmd_t c;
        g         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = CNTW'(cnt);
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        checkOutput("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        c.op      = op;
        c.cnt     = cnt;
        expQ.push_back(c);
    endtask

    task automatic setFin(input logic [1:0] op, input logic rightFin, input logic wrongFin);
        if (op == OP_RUN) begin
            s_fin = rightFin;
            p_fin = wrongFin;
        end else begin
            p_fin = rightFin;
            s_fin = wrongFin;
        end
    endtask

    // Execute the next expected command. dly<0 picks a random completion delay;
    // spur forces spurious pulses (right pulse in START, wrong pulse in WAIT).
    task automatic runCmd(input logic [1:0] op, input int cnt, input int dly, input bit spur);
        int         eff;
        int         g;
        int         rem;
        int         d;
        logic [3:0] expMode;
        eff     = (cnt == 0) ? 1 : cnt;
        expMode = 4'b1000 >> op;
        g       = 0;
        while (modeBus == 4'b0000 && g < 8) begin
            tick();
            g++;
        end
        checkOutput("mode_sel", 32'(modeBus), 32'(expMode));
        if (modeBus != expMode) return;
        if (op == OP_WW || op == OP_BW) begin
            rem = eff;
            g   = 0;
            while (rem > 0 && g < 200) begin
                checkOutput("load_mode", 32'(modeBus), 32'(expMode));
                checkOutput("load_remain", 32'(remain), 32'(rem));
                checkOutput("load_last", 32'(last), 32'(rem == 1));
                checkOutput("load_busy", 32'(busy), 32'd1);
                src_valid = ($urandom_range(0, 3) != 0);
                src_ready = ($urandom_range(0, 3) != 0);
                if (src_valid && src_ready) rem--;
                tick();
                g++;
            end
            src_valid = 1'b0;
            src_ready = 1'b0;
            checkOutput("load_guard", 32'(g < 200), 32'd1);
        end else begin
            for (int s = eff; s >= 1; s--) begin
                checkOutput("start_sinit", 32'(s_init), 32'd1);
                checkOutput("start_mode", 32'(modeBus), 32'(expMode));
                checkOutput("start_remain", 32'(remain), 32'(s));
                checkOutput("start_last", 32'(last), 32'(s == 1));
                setFin(op, spur | 1'($urandom_range(0, 1)), 1'b0);
                tick();
                setFin(op, 1'b0, 1'b0);
                checkOutput("wait_sinit", 32'(s_init), 32'd0);
                d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
                for (int k = 0; k < d; k++) begin
                    checkOutput("wait_remain", 32'(remain), 32'(s));
                    checkOutput("wait_mode", 32'(modeBus), 32'(expMode));
                    checkOutput("wait_sinit_low", 32'(s_init), 32'd0);
                    setFin(op, 1'b0, spur | 1'($urandom_range(0, 1)));
                    tick();
                end
                setFin(op, 1'b1, 1'($urandom_range(0, 1)));
                tick();
                setFin(op, 1'b0, 1'b0);
            end
        end
        checkOutput("done_pulse", 32'(cmd_done), 32'd1);
        checkOutput("done_modes", 32'(modeBus), 32'd0);
        checkOutput("done_remain", 32'(remain), 32'd0);
        checkOutput("done_last", 32'(last), 32'd0);
        tick();
        checkOutput("done_single", 32'(cmd_done), 32'd0);
        checkOutput("gap_modes", 32'(modeBus), 32'd0);
    endtask

    task automatic runNext(input int dly, input bit spur);
        cmd_t c;
        checkOutput("queue_nonempty", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() == 0) return;
        c = expQ.pop_front();
        runCmd(c.op, c.cnt, dly, spur);
    endtask

    initial begin
        int g;
        tests        = 0;
        fails        = 0;
        AXIS_ARESETN = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = '0;
        cmd_cnt      = '0;
        src_valid    = 1'b0;
        src_ready    = 1'b0;
        s_fin        = 1'b0;
        p_fin        = 1'b0;
        repeat (3) tick();

        // Reset state.
        checkOutput("rst_modes", 32'(modeBus), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(cmd_done), 32'd0);
        checkOutput("rst_sinit", 32'(s_init), 32'd0);
        checkOutput("rst_last", 32'(last), 32'd0);
        checkOutput("rst_remain", 32'(remain), 32'd0);
        AXIS_ARESETN = 1'b1;
        tick();

        // WWRITE of 3 beats with random src gaps.
        applyStimulus(OP_WW, 3);
        runNext(-1, 1'b0);

        // RUN of 2 samples, s_fin five cycles after each s_init.
        applyStimulus(OP_RUN, 2);
        runNext(4, 1'b0);

        // POOL of 1 with spurious s_fin, then RUN with count 0 (one sample).
        applyStimulus(OP_POOL, 1);
        runNext(3, 1'b1);
        applyStimulus(OP_RUN, 0);
        runNext(-1, 1'b0);

        // Back-to-back WWRITE then RUN; gap_modes checks the idle cycle between.
        applyStimulus(OP_WW, 2);
        applyStimulus(OP_RUN, 2);
        runNext(-1, 1'b0);
        runNext(-1, 1'b0);

        // Fill the queue behind a stalled WWRITE. The first command leaves the
        // queue at once, so the sixth offer is the one that must be held off.
        applyStimulus(OP_WW, 2);
        applyStimulus(OP_BW, int'($urandom_range(1, 3)));
        for (int i = 0; i < 3; i++)
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        cmd_valid = 1'b1;
        cmd_op    = OP_POOL;
        cmd_cnt   = CNTW'(2);
        checkOutput("full_ready", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        checkOutput("full_hold", 32'(cmd_ready), 32'd0);
        checkOutput("full_busy", 32'(busy), 32'd1);
        runNext(-1, 1'b0);
        checkOutput("full_before_pop", 32'(cmd_ready), 32'd0);
        tick();
        checkOutput("ready_after_pop", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        begin
            cmd_t c;
            c.op  = OP_POOL;
            c.cnt = 2;
            expQ.push_back(c);
        end
        checkOutput("refull_ready", 32'(cmd_ready), 32'd0);
        while (expQ.size() > 0) runNext(-1, 1'b0);

        // Reset while a RUN sits in WAIT with two commands queued behind it.
        applyStimulus(OP_RUN, 3);
        applyStimulus(OP_WW, 2);
        applyStimulus(OP_POOL, 1);
        g = 0;
        while (!(run && !s_init) && g < 10) begin
            tick();
            g++;
        end
        tick();
        checkOutput("pre_rst_run", 32'(run), 32'd1);
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        AXIS_ARESETN = 1'b0;
        #1;
        checkOutput("in_rst_ready", 32'(cmd_ready), 32'd1);
        tick();
        checkOutput("mid_rst_modes", 32'(modeBus), 32'd0);
        checkOutput("mid_rst_sinit", 32'(s_init), 32'd0);
        checkOutput("mid_rst_done", 32'(cmd_done), 32'd0);
        checkOutput("mid_rst_last", 32'(last), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mid_rst_remain", 32'(remain), 32'd0);
        expQ.delete();
        AXIS_ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_rst_modes", 32'(modeBus), 32'd0);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
            checkOutput("post_rst_done", 32'(cmd_done), 32'd0);
        end

        // Random commands, sometimes two queued back to back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1)
                applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            while (expQ.size() > 0) runNext(-1, 1'b0);
        end

        tick();
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
